// File: rtl/immediate_interpreter_pkg.sv
// Shared constants and types for the immediate-operand parser.
// Holds the ASCII characters the parser reacts to, the parser state type
// and a delimiter classifier used by the top level.
package immediate_interpreter_pkg;

  localparam logic [7:0] ASCII_SPACE  = 8'h20;
  localparam logic [7:0] ASCII_COMMA  = 8'h2C;
  localparam logic [7:0] ASCII_LPAREN = 8'h28;
  localparam logic [7:0] ASCII_LF     = 8'h0A;
  localparam logic [7:0] ASCII_CR     = 8'h0D;
  localparam logic [7:0] ASCII_MINUS  = 8'h2D;
  localparam logic [7:0] ASCII_ZERO   = 8'h30;
  localparam logic [7:0] ASCII_X_LO   = 8'h78;
  localparam logic [7:0] ASCII_X_UP   = 8'h58;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SIGN   = 3'd1,
    ST_ZERO   = 3'd2,
    ST_DEC    = 3'd3,
    ST_HEXPFX = 3'd4,
    ST_HEX    = 3'd5,
    ST_RETURN = 3'd6,
    ST_ERROR  = 3'd7
  } imm_state_t;

  // True for any character that may terminate an immediate token.
  function automatic logic is_delim(input logic [7:0] c);
    return (c == ASCII_SPACE) || (c == ASCII_COMMA) || (c == ASCII_LPAREN) ||
           (c == ASCII_LF) || (c == ASCII_CR);
  endfunction

endpackage

// File: rtl/immediate_interpreter_ascii_digit_decode.sv
// Combinational ASCII digit classifier, shared with the register parser.
// Ports:
//   ascii_i   : input character
//   digit_o   : numeric value of the character (0..15), 0 when not a digit
//   is_dec_o  : character is '0'..'9'
//   is_hex_o  : character is '0'..'9', 'a'..'f' or 'A'..'F'
module ascii_digit_decode (
  input  logic [7:0] ascii_i,
  output logic [3:0] digit_o,
  output logic       is_dec_o,
  output logic       is_hex_o
);

  // Classify the character and extract its nibble value.
  always_comb begin
    digit_o  = 4'd0;
    is_dec_o = 1'b0;
    is_hex_o = 1'b0;
    if ((ascii_i >= 8'h30) && (ascii_i <= 8'h39)) begin
      digit_o  = ascii_i[3:0];
      is_dec_o = 1'b1;
      is_hex_o = 1'b1;
    end else if (((ascii_i >= 8'h61) && (ascii_i <= 8'h66)) ||
                 ((ascii_i >= 8'h41) && (ascii_i <= 8'h46))) begin
      // 'a'/'A' have low nibble 1, so adding 9 yields 10..15.
      digit_o  = ascii_i[3:0] + 4'd9;
      is_hex_o = 1'b1;
    end else begin
      digit_o  = 4'd0;
    end
  end

endmodule

// File: rtl/immediate_interpreter.sv
// Immediate-operand parser for the assembler character stream.
// Accepts signed decimal or 0x-prefixed hex, range-checks against an
// IMM_BITS field and returns the two's-complement field plus the delimiter
// that ended the token.
// Ports:
//   clk_in         : system clock
//   rst_in         : asynchronous active-high reset
//   valid_data     : stream qualifier; low returns the parser to idle
//   new_character  : incoming_ascii carries a fresh character this cycle
//   incoming_ascii : character
//   imm_value      : parsed immediate (two's complement), held between parses
//   term_char      : delimiter that ended the last good token
//   done_flag      : one-cycle pulse when imm_value/term_char update
//   error_flag     : high while the parser sits in its error state
module immediate_interpreter
  import immediate_interpreter_pkg::*;
#(
  parameter int IMM_BITS = 12
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                valid_data,
  input  logic                new_character,
  input  logic [7:0]          incoming_ascii,
  output logic [IMM_BITS-1:0] imm_value,
  output logic [7:0]          term_char,
  output logic                done_flag,
  output logic                error_flag
);

  localparam int AW = IMM_BITS + 1;  // accumulator width
  localparam int WW = IMM_BITS + 5;  // wide enough for acc*10+d and acc<<4|d

  localparam logic [AW-1:0] LIM_NEG     = AW'(1'b1) << (IMM_BITS - 1);
  localparam logic [AW-1:0] LIM_DEC_POS = LIM_NEG - AW'(1'b1);
  localparam logic [AW-1:0] LIM_HEX_POS = (AW'(1'b1) << IMM_BITS) - AW'(1'b1);

  imm_state_t          state_q, state_d;
  logic [AW-1:0]       acc_q, acc_d;
  logic                neg_q, neg_d;
  logic                ovf_q, ovf_d;
  logic [IMM_BITS-1:0] imm_q, imm_d;
  logic [7:0]          term_q, term_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [3:0]    digit_s;
  logic          is_dec_s;
  logic          is_hex_s;
  logic          take_s;
  logic          delim_s;
  logic          is_x_s;
  logic [WW-1:0] dec_next_s;
  logic [WW-1:0] hex_next_s;
  logic          dec_ovf_s;
  logic          hex_ovf_s;
  logic [AW-1:0] lim_s;
  logic          range_ok_s;
  logic          finish_s;

  ascii_digit_decode u_digit (
    .ascii_i  (incoming_ascii),
    .digit_o  (digit_s),
    .is_dec_o (is_dec_s),
    .is_hex_o (is_hex_s)
  );

  assign take_s  = valid_data && new_character;
  assign delim_s = is_delim(incoming_ascii);
  assign is_x_s  = (incoming_ascii == ASCII_X_LO) || (incoming_ascii == ASCII_X_UP);

  // acc*10 built from shifts; the extra width exposes any overflow.
  assign dec_next_s = (WW'(acc_q) << 3'd3) + (WW'(acc_q) << 3'd1) + WW'(digit_s);
  assign hex_next_s = (WW'(acc_q) << 3'd4) | WW'(digit_s);
  assign dec_ovf_s  = |dec_next_s[WW-1:IMM_BITS];
  assign hex_ovf_s  = |hex_next_s[WW-1:IMM_BITS];

  // Select the magnitude limit for the token being closed.
  always_comb begin
    lim_s = LIM_DEC_POS;
    if (neg_q) begin
      lim_s = LIM_NEG;
    end else if (state_q == ST_HEX) begin
      lim_s = LIM_HEX_POS;
    end else begin
      lim_s = LIM_DEC_POS;
    end
    range_ok_s = !ovf_q && (acc_q <= lim_s);
  end

  // Next-state, accumulator and output-register logic.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    imm_d    = imm_q;
    term_d   = term_q;
    done_d   = 1'b0;
    finish_s = 1'b0;
    if (!valid_data || (state_q == ST_RETURN)) begin
      // RETURN drops whatever character arrives with it.
      state_d = ST_IDLE;
      acc_d   = {AW{1'b0}};
      neg_d   = 1'b0;
      ovf_d   = 1'b0;
    end else if (take_s) begin
      case (state_q)
        ST_IDLE: begin
          if (incoming_ascii == ASCII_SPACE) begin
            state_d = ST_IDLE;
          end else if (incoming_ascii == ASCII_MINUS) begin
            state_d = ST_SIGN;
            neg_d   = 1'b1;
          end else if (incoming_ascii == ASCII_ZERO) begin
            state_d = ST_ZERO;
          end else if (is_dec_s) begin
            state_d = ST_DEC;
            acc_d   = AW'(digit_s);
          end else begin
            state_d = ST_ERROR;
          end
        end
        ST_SIGN: begin
          if (incoming_ascii == ASCII_ZERO) begin
            state_d = ST_ZERO;
          end else if (is_dec_s) begin
            state_d = ST_DEC;
            acc_d   = AW'(digit_s);
          end else begin
            state_d = ST_ERROR;
          end
        end
        ST_ZERO: begin
          if (is_x_s) begin
            state_d = ST_HEXPFX;
          end else if (is_dec_s) begin
            state_d = ST_DEC;
            acc_d   = dec_next_s[AW-1:0];
            ovf_d   = ovf_q | dec_ovf_s;
          end else if (delim_s) begin
            finish_s = 1'b1;
          end else begin
            state_d = ST_ERROR;
          end
        end
        ST_DEC: begin
          if (is_dec_s) begin
            acc_d = dec_next_s[AW-1:0];
            ovf_d = ovf_q | dec_ovf_s;
          end else if (delim_s) begin
            finish_s = 1'b1;
          end else begin
            state_d = ST_ERROR;
          end
        end
        ST_HEXPFX: begin
          if (is_hex_s) begin
            state_d = ST_HEX;
            acc_d   = AW'(digit_s);
          end else begin
            state_d = ST_ERROR;
          end
        end
        ST_HEX: begin
          if (is_hex_s) begin
            acc_d = hex_next_s[AW-1:0];
            ovf_d = ovf_q | hex_ovf_s;
          end else if (delim_s) begin
            finish_s = 1'b1;
          end else begin
            state_d = ST_ERROR;
          end
        end
        ST_RETURN: state_d = ST_IDLE;
        ST_ERROR:  state_d = ST_ERROR;
        default:   state_d = ST_ERROR;
      endcase

      if (finish_s) begin
        if (range_ok_s) begin
          // Without overflow acc_q < 2^IMM_BITS, so the low bits are the whole magnitude.
          state_d = ST_RETURN;
          imm_d   = neg_q ? (~acc_q[IMM_BITS-1:0] + IMM_BITS'(1'b1)) : acc_q[IMM_BITS-1:0];
          term_d  = incoming_ascii;
          done_d  = 1'b1;
        end else begin
          state_d = ST_ERROR;
        end
      end else begin
        done_d = 1'b0;
      end
    end else begin
      state_d = state_q;
    end
    err_d = (state_d == ST_ERROR);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      acc_q   <= {AW{1'b0}};
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      imm_q   <= {IMM_BITS{1'b0}};
      term_q  <= 8'h00;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      imm_q   <= imm_d;
      term_q  <= term_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign imm_value  = imm_q;
  assign term_char  = term_q;
  assign done_flag  = done_q;
  assign error_flag = err_q;

endmodule

// File: tb/tb_immediate_interpreter.sv
// Self-checking bench: two parser instances (12- and 20-bit fields) share
// one character stream; each token is judged by a string-level reference.
module tb_immediate_interpreter;

  logic        clk_in;
  logic        rst_in;
  logic        valid_data;
  logic        new_character;
  logic [7:0]  incoming_ascii;
  logic [11:0] imm12;
  logic [19:0] imm20;
  logic [7:0]  term12, term20;
  logic        done12, done20, err12, err20;

  int errors = 0;
  int checks = 0;
  logic [31:0] last12 = 32'd0;
  logic [31:0] last20 = 32'd0;
  logic [7:0]  lastt12 = 8'd0;
  logic [7:0]  lastt20 = 8'd0;

  immediate_interpreter #(.IMM_BITS(12)) dut12 (
    .clk_in(clk_in), .rst_in(rst_in), .valid_data(valid_data),
    .new_character(new_character), .incoming_ascii(incoming_ascii),
    .imm_value(imm12), .term_char(term12), .done_flag(done12), .error_flag(err12)
  );

  immediate_interpreter #(.IMM_BITS(20)) dut20 (
    .clk_in(clk_in), .rst_in(rst_in), .valid_data(valid_data),
    .new_character(new_character), .incoming_ascii(incoming_ascii),
    .imm_value(imm20), .term_char(term20), .done_flag(done20), .error_flag(err20)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic bit tb_delim(input byte c);
    return (c == 8'h20) || (c == 8'h2C) || (c == 8'h28) || (c == 8'h0A) || (c == 8'h0D);
  endfunction

  function automatic int hexval(input byte c);
    if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
    if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
    if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
    return -1;
  endfunction

  // Token-level reference: s is a whole token ending in its delimiter.
  function automatic void model(input string s, input int bits, output bit ok,
                                output logic [31:0] val, output logic [7:0] term);
    int     i = 0;
    int     n = s.len() - 1;
    int     nd = 0;
    int     d;
    bit     neg = 1'b0;
    bit     hex = 1'b0;
    longint mag = 0;
    longint lim;
    longint mask = (longint'(1) << bits) - 1;
    ok = 1'b0;
    val = 32'd0;
    term = s[n];
    while (i < n && s[i] == 8'h20) i++;
    if (i < n && s[i] == 8'h2D) begin neg = 1'b1; i++; end
    if (i + 1 < n && s[i] == 8'h30 && (s[i+1] == 8'h78 || s[i+1] == 8'h58)) begin
      hex = 1'b1;
      i += 2;
    end
    for (; i < n; i++) begin
      d = hexval(s[i]);
      if (d < 0 || (!hex && d > 9)) return;
      mag = hex ? mag * 16 + d : mag * 10 + d;
      if (mag > (longint'(1) << 40)) mag = longint'(1) << 40;
      nd++;
    end
    if (nd == 0 || !tb_delim(s[n])) return;
    if (neg) lim = longint'(1) << (bits - 1);
    else if (hex) lim = mask;
    else lim = (longint'(1) << (bits - 1)) - 1;
    if (mag > lim) return;
    ok = 1'b1;
    val = 32'((neg ? -mag : mag) & mask);
  endfunction

  task automatic send(input byte c);
    valid_data = 1'b1;
    new_character = 1'b1;
    incoming_ascii = c;
    @(posedge clk_in); #1;
    new_character = 1'b0;
    incoming_ascii = 8'($urandom);
  endtask

  task automatic do_token(input string s, input bit gaps);
    bit ok12, ok20;
    logic [31:0] v12, v20;
    logic [7:0] t;
    int pre_done = 0;
    model(s, 12, ok12, v12, t);
    model(s, 20, ok20, v20, t);
    for (int i = 0; i < s.len(); i++) begin
      send(s[i]);
      if (i < s.len() - 1) begin
        if (done12 || done20) pre_done++;
        if (gaps) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk_in); #1;
            if (done12 || done20) pre_done++;
          end
        end
      end
    end
    chk({"done_early ", s}, pre_done, 0);
    chk({"done12 ", s}, done12, ok12);
    chk({"done20 ", s}, done20, ok20);
    if (ok12) begin
      chk({"imm12 ", s}, imm12, v12);
      chk({"term12 ", s}, term12, t);
      last12 = v12; lastt12 = t;
    end else begin
      chk({"err12 ", s}, err12, 1'b1);
    end
    if (ok20) begin
      chk({"imm20 ", s}, imm20, v20);
      chk({"term20 ", s}, term20, t);
      last20 = v20; lastt20 = t;
    end else begin
      chk({"err20 ", s}, err20, 1'b1);
    end
    @(posedge clk_in); #1;
    chk({"pulse12 ", s}, done12, 1'b0);
    chk({"pulse20 ", s}, done20, 1'b0);
    chk({"hold12 ", s}, imm12, last12);
    chk({"hold20 ", s}, imm20, last20);
    chk({"sticky12 ", s}, err12, !ok12);
    chk({"sticky20 ", s}, err20, !ok20);
    if (!ok12 || !ok20) begin
      valid_data = 1'b0;
      @(posedge clk_in); #1;
      chk({"errclr12 ", s}, err12, 1'b0);
      chk({"errclr20 ", s}, err20, 1'b0);
      chk({"termhold12 ", s}, term12, lastt12);
      valid_data = 1'b1;
    end
  endtask

  function automatic string gen_token();
    byte    dl [5] = '{8'h20, 8'h2C, 8'h28, 8'h0A, 8'h0D};
    longint edges [10] = '{2047, 2048, 2049, 4095, 4096, 524287, 524288, 524289, 1048575, 1048576};
    longint mag;
    bit     hex = 1'($urandom_range(0, 1));
    string  body, s;
    case ($urandom_range(0, 2))
      0:       mag = $urandom_range(0, 5000);
      1:       mag = edges[$urandom_range(0, 9)];
      default: mag = $urandom_range(0, 1100000);
    endcase
    body = hex ? $sformatf("%0h", mag) : $sformatf("%0d", mag);
    if (hex && $urandom_range(0, 1) == 1) body = body.toupper();
    s = "";
    if ($urandom_range(0, 3) == 0) s = " ";
    if ($urandom_range(0, 2) == 0) s = {s, "-"};
    if (hex) s = ($urandom_range(0, 1) == 1) ? {s, "0x"} : {s, "0X"};
    s = {s, body, " "};
    if ($urandom_range(0, 7) == 0) s[$urandom_range(0, s.len() - 2)] = 8'h67;
    s[s.len() - 1] = dl[$urandom_range(0, 4)];
    return s;
  endfunction

  initial begin
    rst_in = 1'b1;
    valid_data = 1'b0;
    new_character = 1'b0;
    incoming_ascii = 8'h00;
    repeat (2) @(posedge clk_in); #1;
    chk("rst_imm12", imm12, 32'd0);
    chk("rst_imm20", imm20, 32'd0);
    chk("rst_term12", term12, 32'd0);
    chk("rst_done12", done12, 1'b0);
    chk("rst_done20", done20, 1'b0);
    chk("rst_err12", err12, 1'b0);
    rst_in = 1'b0;
    valid_data = 1'b1;

    do_token("2047,", 1'b0);
    do_token("-2048 ", 1'b0);
    do_token("2048 ", 1'b0);
    do_token("0x7fF(", 1'b0);
    do_token("-0x10 ", 1'b0);
    do_token("0x1000 ", 1'b0);
    do_token("0xFFFFF ", 1'b0);
    do_token("12a ", 1'b0);
    do_token("- ", 1'b0);
    do_token("0x ", 1'b0);
    do_token("x5 ", 1'b0);
    do_token("99999999999 ", 1'b0);
    do_token("  5 ", 1'b1);
    do_token("0 ", 1'b0);

    // Back-to-back: the '4' lands in the RETURN cycle and is lost.
    send(8'h33);
    send(8'h2C);
    chk("b2b_done3", done12, 1'b1);
    chk("b2b_imm3", imm12, 32'd3);
    send(8'h34);
    chk("b2b_drop", done12, 1'b0);
    last12 = 32'd3; last20 = 32'd3; lastt12 = 8'h2C; lastt20 = 8'h2C;
    do_token("4,", 1'b0);

    // Dropping valid_data abandons a partial token.
    send(8'h31);
    send(8'h32);
    valid_data = 1'b0;
    @(posedge clk_in); #1;
    chk("vdrop_imm12", imm12, last12);
    chk("vdrop_err12", err12, 1'b0);
    chk("vdrop_done12", done12, 1'b0);
    valid_data = 1'b1;
    do_token("7,", 1'b0);

    for (int k = 0; k < 40; k++) do_token(gen_token(), k[0]);

    // Reset raised mid-cycle must clear outputs before the next edge.
    send(8'h31);
    send(8'h32);
    #3 rst_in = 1'b1;
    #1;
    chk("arst_imm12", imm12, 32'd0);
    chk("arst_imm20", imm20, 32'd0);
    chk("arst_term20", term20, 32'd0);
    chk("arst_err20", err20, 1'b0);
    @(negedge clk_in);
    rst_in = 1'b0;
    last12 = 32'd0; last20 = 32'd0; lastt12 = 8'd0; lastt20 = 8'd0;
    do_token("-1 ", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
